reg_wb_writer: RTL and testbench

- Write-side producer for the CPU register file.
- Merges two writeback sources into the single register-file write port, one write per cycle:
  - ALU results: single-cycle, high priority.
  - Load results: variable latency from data memory, buffered in a FIFO.
- Drives the RegWre / writeReg / writeData triple from registers.
- Exposes pending-write lookups so decode can stall on in-flight loads.

---
 rtl/reg_wb_writer_pkg.sv | 19 +
 rtl/wb_load_fifo.sv | 55 +++++
 rtl/reg_wb_writer.sv | 94 +++++++++
 tb/tb_reg_wb_writer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_writer_pkg.sv
// reg_wb_writer_pkg: shared widths, writeback request record and zero-register helpers
package reg_wb_writer_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

    function automatic logic rd_hit(
        input logic                  vld,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] q
    );
        return vld && (q != ZERO_REG) && (rd == q);
    endfunction
endpackage

// File: rtl/wb_load_fifo.sv
// wb_load_fifo: synchronous FIFO of writeback requests with a per-entry rd/valid view
module wb_load_fifo
    import reg_wb_writer_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 push_i,
    input  wb_req_t                              req_i,
    input  logic                                 pop_i,
    output wb_req_t                              head_o,
    output logic                                 full_o,
    output logic                                 empty_o,
    output logic [PW:0]                          count_o,
    output logic [DEPTH-1:0]                     vld_o,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]     rd_o
);
    wb_req_t       mem_q [DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [PW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = cnt_q == (PW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign head_o  = mem_q[rp_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + PW'(1);
            if (do_pop) rp_q <= rp_q + PW'(1);
            cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wp_q] <= req_i;
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    for (genvar g = 0; g < DEPTH; g++) begin : g_view
        logic [PW-1:0] off;
        assign off      = PW'(g) - rp_q;
        assign vld_o[g] = {1'b0, off} < cnt_q;
        assign rd_o[g]  = mem_q[g].rd;
    end
endmodule

// File: rtl/reg_wb_writer.sv
// reg_wb_writer: merges ALU and buffered load results onto the register-file write port
module reg_wb_writer
    import reg_wb_writer_pkg::*;
#(
    parameter  int LQ_DEPTH     = 4,
    parameter  int STARVE_LIMIT = 3,
    localparam int CW           = $clog2(LQ_DEPTH) + 1,
    localparam int SW           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic [REG_ADDR_W-1:0] q_rs,
    input  logic [REG_ADDR_W-1:0] q_rt,
    output logic                  pend_rs,
    output logic                  pend_rt,
    output logic                  RegWre,
    output logic [REG_ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0]     writeData,
    output logic [CW-1:0]         lq_count
);
    wb_req_t                               head, grant_req;
    logic                                  full, empty, alu_grant, lq_push, lq_pop;
    logic [LQ_DEPTH-1:0]                   ent_vld;
    logic [LQ_DEPTH-1:0][REG_ADDR_W-1:0]   ent_rd;
    logic [SW-1:0]                         starve_q, starve_d;
    logic                                  we_q, we_d;
    logic [REG_ADDR_W-1:0]                 wreg_q, wreg_d;
    logic [DATA_W-1:0]                     wdata_q, wdata_d;

    wb_load_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
        .clk_i   (CLK),
        .rst_ni  (Reset),
        .push_i  (lq_push),
        .req_i   ({mem_rd, mem_data}),
        .pop_i   (lq_pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (lq_count),
        .vld_o   (ent_vld),
        .rd_o    (ent_rd)
    );

    assign alu_ready = Reset && (empty || starve_q != SW'(STARVE_LIMIT));
    assign mem_ready = Reset && !full;
    assign alu_grant = alu_valid && alu_ready;
    assign lq_pop    = Reset && !alu_grant && !empty;
    assign lq_push   = mem_valid && mem_ready;
    assign grant_req = alu_grant ? {alu_rd, alu_data} : head;

    // Writes to r0 still consume their grant but never reach the register file.
    always_comb begin
        starve_d = (lq_pop || empty) ? '0
                 : (alu_grant && starve_q != SW'(STARVE_LIMIT)) ? starve_q + SW'(1) : starve_q;
        we_d     = (alu_grant || lq_pop) && grant_req.rd != ZERO_REG;
        wreg_d   = we_d ? grant_req.rd : wreg_q;
        wdata_d  = we_d ? grant_req.data : wdata_q;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            starve_q <= '0;
            we_q     <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
        end else begin
            starve_q <= starve_d;
            we_q     <= we_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
        end
    end

    assign RegWre    = we_q;
    assign writeReg  = wreg_q;
    assign writeData = wdata_q;

    always_comb begin
        pend_rs = rd_hit(we_q, wreg_q, q_rs);
        pend_rt = rd_hit(we_q, wreg_q, q_rt);
        for (int i = 0; i < LQ_DEPTH; i++) begin
            pend_rs = pend_rs | rd_hit(ent_vld[i], ent_rd[i], q_rs);
            pend_rt = pend_rt | rd_hit(ent_vld[i], ent_rd[i], q_rt);
        end
    end
endmodule

// File: tb/tb_reg_wb_writer.sv
// tb_reg_wb_writer: directed scenarios plus randomized traffic against a queue-based model
module tb_reg_wb_writer;
    logic        CLK = 1'b0, Reset = 1'b0;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic        alu_ready, mem_ready, pend_rs, pend_rt, RegWre;
    logic [4:0]  alu_rd = '0, mem_rd = '0, q_rs = '0, q_rt = '0, writeReg;
    logic [31:0] alu_data = '0, mem_data = '0, writeData;
    logic [2:0]  lq_count;
    int          checks = 0, passed = 0;

    reg_wb_writer dut (
        .CLK(CLK), .Reset(Reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .q_rs(q_rs), .q_rt(q_rt), .pend_rs(pend_rs), .pend_rt(pend_rt),
        .RegWre(RegWre), .writeReg(writeReg), .writeData(writeData), .lq_count(lq_count)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
    ent_t        mq[$];
    int          streak = 0;
    logic        m_we = 1'b0;
    logic [4:0]  m_reg = '0;
    logic [31:0] m_data = '0;
    bit          acc_a, acc_m;
    logic [4:0]  rd_pool [5] = '{5'd0, 5'd3, 5'd9, 5'd17, 5'd31};

    function automatic logic m_alu_rdy();
        return Reset && (mq.size() == 0 || streak < 3);
    endfunction

    function automatic logic m_mem_rdy();
        return Reset && mq.size() < 4;
    endfunction

    function automatic logic m_pend(input logic [4:0] r);
        if (r == 0) return 1'b0;
        if (m_we && m_reg == r) return 1'b1;
        foreach (mq[i]) if (mq[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        streak = 0;
        m_we = 1'b0;
        m_reg = '0;
        m_data = '0;
    endtask

    task automatic tick();
        ent_t g;
        bit   iss, was_empty;
        g = '{5'd0, 32'd0};
        was_empty = mq.size() == 0;
        acc_a = alu_valid && m_alu_rdy();
        acc_m = mem_valid && m_mem_rdy();
        iss = Reset && !acc_a && !was_empty;
        if (acc_a) g = '{alu_rd, alu_data};
        else if (iss) g = mq.pop_front();
        m_we = (acc_a || iss) && g.rd != 0;
        if (m_we) begin m_reg = g.rd; m_data = g.data; end
        streak = (iss || was_empty) ? 0 : (acc_a && streak < 3) ? streak + 1 : streak;
        if (acc_m) mq.push_back('{mem_rd, mem_data});
        if (!Reset) model_reset();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        alu_valid = 1'b1; mem_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11; mem_rd = 5'd10;
        #2;
        checks++; if (RegWre !== 1'b0) $display("FAIL rst_we got=%0b exp=0", RegWre); else passed++;
        checks++; if (writeReg !== 5'd0) $display("FAIL rst_reg got=%0d exp=0", writeReg); else passed++;
        checks++; if (writeData !== 32'd0) $display("FAIL rst_data got=%h exp=0", writeData); else passed++;
        checks++; if (lq_count !== 3'd0) $display("FAIL rst_count got=%0d exp=0", lq_count); else passed++;
        checks++; if (alu_ready !== 1'b0) $display("FAIL rst_alu_ready got=%0b exp=0", alu_ready); else passed++;
        checks++; if (mem_ready !== 1'b0) $display("FAIL rst_mem_ready got=%0b exp=0", mem_ready); else passed++;
        tick();
        Reset = 1'b1;
        tick();
        mem_rd = 5'd11;
        tick();
        mem_valid = 1'b0;
        checks++; if (lq_count !== 3'd2) $display("FAIL midrst_fill got=%0d exp=2", lq_count); else passed++;
        checks++; if (RegWre !== 1'b1) $display("FAIL midrst_pre_we got=%0b exp=1", RegWre); else passed++;
        #2 Reset = 1'b0;
        #1 model_reset();
        checks++; if (RegWre !== 1'b0) $display("FAIL midrst_we got=%0b exp=0", RegWre); else passed++;
        checks++; if (lq_count !== 3'd0) $display("FAIL midrst_count got=%0d exp=0", lq_count); else passed++;
        alu_valid = 1'b0;
        tick();
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (RegWre !== 1'b0) $display("FAIL postrst_we[%0d] got=%0b exp=0", i, RegWre); else passed++;
        end
    endtask

    task automatic test_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        #1;
        checks++; if (alu_ready !== 1'b1) $display("FAIL alu_ready got=%0b exp=1", alu_ready); else passed++;
        tick();
        alu_valid = 1'b0;
        checks++; if (RegWre !== 1'b1) $display("FAIL alu_we got=%0b exp=1", RegWre); else passed++;
        checks++; if (writeReg !== 5'd5) $display("FAIL alu_reg got=%0d exp=5", writeReg); else passed++;
        checks++; if (writeData !== 32'h1234) $display("FAIL alu_data got=%h exp=1234", writeData); else passed++;
        tick();
        checks++; if (RegWre !== 1'b0) $display("FAIL alu_idle_we got=%0b exp=0", RegWre); else passed++;
        checks++; if (writeReg !== 5'd5) $display("FAIL alu_hold_reg got=%0d exp=5", writeReg); else passed++;
    endtask

    task automatic test_zero_load();
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFF_FFFF;
        tick();
        checks++; if (lq_count !== 3'd1) $display("FAIL zl_count1 got=%0d exp=1", lq_count); else passed++;
        checks++; if (RegWre !== 1'b0) $display("FAIL zl_we0 got=%0b exp=0", RegWre); else passed++;
        mem_rd = 5'd7; mem_data = 32'hA5A5_A5A5; q_rt = 5'd0;
        #1;
        checks++; if (pend_rt !== 1'b0) $display("FAIL zl_pend_r0 got=%0b exp=0", pend_rt); else passed++;
        tick();
        mem_valid = 1'b0;
        checks++; if (RegWre !== 1'b0) $display("FAIL zl_r0_we got=%0b exp=0", RegWre); else passed++;
        checks++; if (lq_count !== 3'd1) $display("FAIL zl_count2 got=%0d exp=1", lq_count); else passed++;
        tick();
        checks++; if (RegWre !== 1'b1) $display("FAIL zl_we got=%0b exp=1", RegWre); else passed++;
        checks++; if (writeReg !== 5'd7) $display("FAIL zl_reg got=%0d exp=7", writeReg); else passed++;
        checks++; if (writeData !== 32'hA5A5_A5A5) $display("FAIL zl_data got=%h exp=a5a5a5a5", writeData); else passed++;
        checks++; if (lq_count !== 3'd0) $display("FAIL zl_count0 got=%0d exp=0", lq_count); else passed++;
    endtask

    task automatic test_starve();
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'd0;
        mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'hC0DE;
        tick();
        mem_valid = 1'b0;
        checks++; if (writeReg !== 5'd4 || RegWre !== 1'b1) $display("FAIL st_first got=%0d/%0b exp=4/1", writeReg, RegWre); else passed++;
        for (int k = 1; k <= 3; k++) begin
            alu_data = k;
            #1;
            checks++; if (alu_ready !== 1'b1) $display("FAIL st_ready[%0d] got=%0b exp=1", k, alu_ready); else passed++;
            tick();
            checks++; if (writeReg !== 5'd4 || writeData !== k) $display("FAIL st_alu[%0d] got=%0d/%0d exp=4/%0d", k, writeReg, writeData, k); else passed++;
        end
        #1;
        checks++; if (alu_ready !== 1'b0) $display("FAIL st_blocked got=%0b exp=0", alu_ready); else passed++;
        tick();
        checks++; if (writeReg !== 5'd12 || writeData !== 32'hC0DE) $display("FAIL st_load got=%0d/%h exp=12/c0de", writeReg, writeData); else passed++;
        #1;
        checks++; if (alu_ready !== 1'b1) $display("FAIL st_resume_ready got=%0b exp=1", alu_ready); else passed++;
        tick();
        alu_valid = 1'b0;
        checks++; if (writeReg !== 5'd4 || writeData !== 32'd3) $display("FAIL st_resume got=%0d/%0d exp=4/3", writeReg, writeData); else passed++;
    endtask

    task automatic test_full();
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1'b1; mem_rd = 5'(20 + i); mem_data = i;
            #1;
            checks++; if (mem_ready !== 1'b1) $display("FAIL full_push_ready[%0d] got=%0b exp=1", i, mem_ready); else passed++;
            tick();
        end
        mem_rd = 5'd24; mem_data = 32'd4;
        #1;
        checks++; if (lq_count !== 3'd4) $display("FAIL full_count got=%0d exp=4", lq_count); else passed++;
        checks++; if (mem_ready !== 1'b0) $display("FAIL full_mem_ready got=%0b exp=0", mem_ready); else passed++;
        checks++; if (alu_ready !== 1'b0) $display("FAIL full_alu_ready got=%0b exp=0", alu_ready); else passed++;
        tick();
        checks++; if (writeReg !== 5'd20 || lq_count !== 3'd3) $display("FAIL full_pop got=%0d/%0d exp=20/3", writeReg, lq_count); else passed++;
        #1;
        checks++; if (mem_ready !== 1'b1) $display("FAIL full_reopen got=%0b exp=1", mem_ready); else passed++;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        checks++; if (writeReg !== 5'd2 || lq_count !== 3'd4) $display("FAIL full_refill got=%0d/%0d exp=2/4", writeReg, lq_count); else passed++;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++; if (RegWre !== 1'b1 || writeReg !== 5'(20 + i) || writeData !== i)
                $display("FAIL full_drain[%0d] got=%0b/%0d/%0d exp=1/%0d/%0d", i, RegWre, writeReg, writeData, 20 + i, i); else passed++;
        end
        checks++; if (lq_count !== 3'd0) $display("FAIL full_empty got=%0d exp=0", lq_count); else passed++;
    endtask

    task automatic test_pending();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
        tick();
        mem_rd = 5'd0; mem_data = 32'h0;
        tick();
        mem_valid = 1'b0; q_rs = 5'd9; q_rt = 5'd0;
        #1;
        checks++; if (pend_rs !== 1'b1) $display("FAIL pend_first got=%0b exp=1", pend_rs); else passed++;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (pend_rs !== m_pend(9)) $display("FAIL pend_rs[%0d] got=%0b exp=%0b", i, pend_rs, m_pend(9)); else passed++;
            checks++; if (pend_rt !== 1'b0) $display("FAIL pend_r0[%0d] got=%0b exp=0", i, pend_rt); else passed++;
            tick();
        end
        alu_valid = 1'b0;
        #1;
        checks++; if (pend_rs !== 1'b0) $display("FAIL pend_cleared got=%0b exp=0", pend_rs); else passed++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if (!alu_valid && $urandom_range(0, 2) != 0) begin
                alu_valid = 1'b1; alu_rd = rd_pool[$urandom_range(0, 4)]; alu_data = $urandom;
            end
            if (!mem_valid && $urandom_range(0, 1) == 0) begin
                mem_valid = 1'b1; mem_rd = rd_pool[$urandom_range(0, 4)]; mem_data = $urandom;
            end
            q_rs = rd_pool[$urandom_range(0, 4)];
            q_rt = rd_pool[$urandom_range(0, 4)];
            #1;
            checks++; if (alu_ready !== m_alu_rdy()) $display("FAIL rnd_alu_ready[%0d] got=%0b exp=%0b", c, alu_ready, m_alu_rdy()); else passed++;
            checks++; if (mem_ready !== m_mem_rdy()) $display("FAIL rnd_mem_ready[%0d] got=%0b exp=%0b", c, mem_ready, m_mem_rdy()); else passed++;
            checks++; if (pend_rs !== m_pend(q_rs)) $display("FAIL rnd_pend_rs[%0d] got=%0b exp=%0b", c, pend_rs, m_pend(q_rs)); else passed++;
            checks++; if (pend_rt !== m_pend(q_rt)) $display("FAIL rnd_pend_rt[%0d] got=%0b exp=%0b", c, pend_rt, m_pend(q_rt)); else passed++;
            tick();
            if (acc_a) alu_valid = 1'b0;
            if (acc_m) mem_valid = 1'b0;
            checks++; if (RegWre !== m_we) $display("FAIL rnd_we[%0d] got=%0b exp=%0b", c, RegWre, m_we); else passed++;
            if (m_we) begin
                checks++; if (writeReg !== m_reg || writeData !== m_data)
                    $display("FAIL rnd_write[%0d] got=%0d/%h exp=%0d/%h", c, writeReg, writeData, m_reg, m_data); else passed++;
            end
            checks++; if (lq_count !== 3'(mq.size())) $display("FAIL rnd_count[%0d] got=%0d exp=%0d", c, lq_count, mq.size()); else passed++;
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_zero_load();
        test_starve();
        test_full();
        test_pending();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
